pc_predict_unit: RTL and testbench

//  Next-generation fetch-PC generator. Holds the architectural fetch PC and predicts the next PC

---
 rtl/pc_predict_unit_pkg.sv | 29 ++
 rtl/pc_predict_unit_btb_table.sv | 67 ++++++
 rtl/pc_predict_unit.sv | 111 +++++++++++
 tb/tb_pc_predict_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_predict_unit_pkg.sv
// Shared definitions for the fetch-PC predictor: counter encodings, reset PC
// default and BTB field-width helpers.
package pc_predict_unit_pkg;

  localparam int          DEF_BIT_W     = 32;
  localparam int          DEF_BTB_DEPTH = 16;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0001_0000;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Tag covers everything above the index and the two word-offset bits.
  function automatic int tag_w(input int bit_w, input int idx_w);
    return bit_w - idx_w - 2;
  endfunction

  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    logic [1:0] v;
    v = c;
    if (taken && (c != CTR_ST)) v = v + 2'd1;
    else if (!taken && (c != CTR_SNT)) v = v - 2'd1;
    return ctr_e'(v);
  endfunction

endpackage

// File: rtl/pc_predict_unit_btb_table.sv
// Direct-mapped BTB storage: two async read ports (fetch lookup, EX training
// lookup) and one synchronous write port. Only valid bits are reset.
module pc_predict_unit_btb_table
  import pc_predict_unit_pkg::*;
#(
  parameter int BIT_W = DEF_BIT_W,
  parameter int IDX_W = 4,
  parameter int TAG_W = tag_w(BIT_W, IDX_W)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [BIT_W-1:0] o_rd_target,
  output logic             o_rd_jump,
  output ctr_e             o_rd_ctr,
  input  logic [IDX_W-1:0] i_tr_idx,
  output logic             o_tr_valid,
  output logic [TAG_W-1:0] o_tr_tag,
  output logic [BIT_W-1:0] o_tr_target,
  output logic             o_tr_jump,
  output ctr_e             o_tr_ctr,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [BIT_W-1:0] i_wr_target,
  input  logic             i_wr_jump,
  input  ctr_e             i_wr_ctr
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [BIT_W-1:0] r_target [DEPTH];
  logic             r_jump   [DEPTH];
  ctr_e             r_ctr    [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_valid <= '0;
    else if (i_we) r_valid[i_wr_idx] <= 1'b1;
  end

  // Payload needs no reset: it is never observed while its valid bit is clear.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]    <= i_wr_tag;
      r_target[i_wr_idx] <= i_wr_target;
      r_jump[i_wr_idx]   <= i_wr_jump;
      r_ctr[i_wr_idx]    <= i_wr_ctr;
    end
  end

  assign o_rd_valid  = r_valid[i_rd_idx];
  assign o_rd_tag    = r_tag[i_rd_idx];
  assign o_rd_target = r_target[i_rd_idx];
  assign o_rd_jump   = r_jump[i_rd_idx];
  assign o_rd_ctr    = r_ctr[i_rd_idx];

  assign o_tr_valid  = r_valid[i_tr_idx];
  assign o_tr_tag    = r_tag[i_tr_idx];
  assign o_tr_target = r_target[i_tr_idx];
  assign o_tr_jump   = r_jump[i_tr_idx];
  assign o_tr_ctr    = r_ctr[i_tr_idx];

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-PC generator: PC register, BTB-based next-PC prediction, EX-stage
// mispredict detection/redirect and BTB training.
module pc_predict_unit
  import pc_predict_unit_pkg::*;
#(
  parameter int               BIT_W     = DEF_BIT_W,
  parameter int               BTB_DEPTH = DEF_BTB_DEPTH,
  parameter logic [BIT_W-1:0] RESET_PC  = BIT_W'(DEF_RESET_PC)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_cond,
  input  logic [BIT_W-1:0] i_ex_pc,
  input  logic             i_ex_taken,
  input  logic [BIT_W-1:0] i_ex_target,
  input  logic             i_ex_pred_taken,
  input  logic [BIT_W-1:0] i_ex_pred_target,
  output logic [BIT_W-1:0] o_PC,
  output logic [BIT_W-1:0] o_PCPlus4,
  output logic             o_pred_taken,
  output logic [BIT_W-1:0] o_pred_target,
  output logic             o_flush
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = tag_w(BIT_W, IDX_W);

  logic [BIT_W-1:0] r_pc;
  logic [BIT_W-1:0] w_next_pc, w_correct_pc;
  logic [IDX_W-1:0] w_idx, w_ex_idx;
  logic [TAG_W-1:0] w_tag, w_ex_tag;
  logic             w_rd_valid, w_rd_jump, w_hit;
  logic [TAG_W-1:0] w_rd_tag;
  logic [BIT_W-1:0] w_rd_target;
  ctr_e             w_rd_ctr;
  logic             w_tr_valid, w_tr_jump, w_ex_hit;
  logic [TAG_W-1:0] w_tr_tag;
  logic [BIT_W-1:0] w_tr_target;
  ctr_e             w_tr_ctr;
  logic             w_we, w_wr_jump;
  logic [BIT_W-1:0] w_wr_target;
  ctr_e             w_wr_ctr;

  assign w_idx     = r_pc[IDX_W+1:2];
  assign w_tag     = r_pc[BIT_W-1:IDX_W+2];
  assign w_ex_idx  = i_ex_pc[IDX_W+1:2];
  assign w_ex_tag  = i_ex_pc[BIT_W-1:IDX_W+2];

  assign o_PC      = r_pc;
  assign o_PCPlus4 = r_pc + BIT_W'(4);

  assign w_hit         = w_rd_valid && (w_rd_tag == w_tag);
  assign o_pred_taken  = w_hit && (w_rd_jump || (w_rd_ctr == CTR_WT) || (w_rd_ctr == CTR_ST));
  assign o_pred_target = w_hit ? w_rd_target : o_PCPlus4;

  // i_ex_valid qualifies every i_ex_* field for exactly one cycle; there is no
  // back-pressure, so a resolution is consumed in the cycle it is presented.
  assign o_flush = i_ex_valid &&
                   ((i_ex_taken != i_ex_pred_taken) ||
                    (i_ex_taken && (i_ex_target != i_ex_pred_target)));
  assign w_correct_pc = i_ex_taken ? i_ex_target : (i_ex_pc + BIT_W'(4));

  always_comb begin
    w_next_pc = o_PCPlus4;
    if (o_flush)           w_next_pc = w_correct_pc;
    else if (i_stall)      w_next_pc = r_pc;
    else if (o_pred_taken) w_next_pc = o_pred_target;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pc <= RESET_PC;
    else          r_pc <= w_next_pc;
  end

  // Training: hits update counter/target in place; taken misses (re)allocate.
  assign w_ex_hit    = w_tr_valid && (w_tr_tag == w_ex_tag);
  assign w_we        = i_ex_valid && (w_ex_hit || i_ex_taken);
  assign w_wr_target = i_ex_taken ? {i_ex_target[BIT_W-1:1], 1'b0} : w_tr_target;
  assign w_wr_jump   = w_ex_hit ? w_tr_jump : !i_ex_is_cond;
  assign w_wr_ctr    = w_ex_hit ? ctr_next(w_tr_ctr, i_ex_taken) : CTR_WT;

  pc_predict_unit_btb_table #(
    .BIT_W (BIT_W),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_btb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rd_idx    (w_idx),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_target (w_rd_target),
    .o_rd_jump   (w_rd_jump),
    .o_rd_ctr    (w_rd_ctr),
    .i_tr_idx    (w_ex_idx),
    .o_tr_valid  (w_tr_valid),
    .o_tr_tag    (w_tr_tag),
    .o_tr_target (w_tr_target),
    .o_tr_jump   (w_tr_jump),
    .o_tr_ctr    (w_tr_ctr),
    .i_we        (w_we),
    .i_wr_idx    (w_ex_idx),
    .i_wr_tag    (w_ex_tag),
    .i_wr_target (w_wr_target),
    .i_wr_jump   (w_wr_jump),
    .i_wr_ctr    (w_wr_ctr)
  );

endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit: directed scenarios plus random traffic, all
// checked against an address-level BTB/PC reference model.
module tb_pc_predict_unit;

  localparam int          DEPTH    = 16;
  localparam logic [31:0] RESET_PC = 32'h0001_0000;

  logic        clk, rst_n;
  logic        stall, ex_valid, ex_is_cond, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic [31:0] o_pc, o_pcplus4, o_pred_target;
  logic        o_pred_taken, o_flush;

  pc_predict_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_stall          (stall),
    .i_ex_valid       (ex_valid),
    .i_ex_is_cond     (ex_is_cond),
    .i_ex_pc          (ex_pc),
    .i_ex_taken       (ex_taken),
    .i_ex_target      (ex_target),
    .i_ex_pred_taken  (ex_pred_taken),
    .i_ex_pred_target (ex_pred_target),
    .o_PC             (o_pc),
    .o_PCPlus4        (o_pcplus4),
    .o_pred_taken     (o_pred_taken),
    .o_pred_target    (o_pred_target),
    .o_flush          (o_flush)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: run did not finish, got=running exp=finished");
    $fatal(1, "timeout");
  end

  // reference model: entries remember the full PC of the owning instruction
  bit          m_v     [DEPTH];
  logic [31:0] m_owner [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  bit          m_jump  [DEPTH];
  int          m_ctr   [DEPTH];
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(DEPTH));
  endfunction

  function automatic logic [31:0] region(input logic [31:0] pc);
    return pc / 32'(4 * DEPTH);
  endfunction

  task automatic model_lookup(input logic [31:0] pc, output bit pt, output logic [31:0] tg);
    int s;
    s  = slot(pc);
    pt = 1'b0;
    tg = pc + 32'd4;
    if (m_v[s] && region(m_owner[s]) == region(pc)) begin
      pt = m_jump[s] || (m_ctr[s] >= 2);
      tg = m_tgt[s];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
  endtask

  task automatic model_train(input bit cond, input logic [31:0] epc, input bit tk, input logic [31:0] tgt);
    int s;
    s = slot(epc);
    if (m_v[s] && region(m_owner[s]) == region(epc)) begin
      m_ctr[s] = tk ? ((m_ctr[s] == 3) ? 3 : m_ctr[s] + 1) : ((m_ctr[s] == 0) ? 0 : m_ctr[s] - 1);
      if (tk) m_tgt[s] = tgt & ~32'd1;
    end else if (tk) begin
      m_v[s]     = 1'b1;
      m_owner[s] = epc;
      m_tgt[s]   = tgt & ~32'd1;
      m_jump[s]  = !cond;
      m_ctr[s]   = 2;
    end
  endtask

  // driver: called away from the clock edge; returns at the following negedge
  task automatic step(input bit st, input bit v, input bit cond, input logic [31:0] epc,
                      input bit tk, input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    logic [31:0] pc_e, pt_tgt, corr, nxt;
    bit          pt, fl;
    stall = st; ex_valid = v; ex_is_cond = cond; ex_pc = epc;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
    pc_e = exp_q.pop_front();
    model_lookup(pc_e, pt, pt_tgt);
    fl   = v && ((tk != ptk) || (tk && (tgt != ptgt)));
    corr = tk ? tgt : epc + 32'd4;
    check_val("pc", o_pc, pc_e);
    check_val("pcplus4", o_pcplus4, pc_e + 32'd4);
    check_val("pred_taken", 32'(o_pred_taken), 32'(pt));
    check_val("pred_target", o_pred_target, pt_tgt);
    check_val("flush", 32'(o_flush), 32'(fl));
    nxt = fl ? corr : (st ? pc_e : (pt ? pt_tgt : pc_e + 32'd4));
    @(posedge clk);
    if (v) model_train(cond, epc, tk, tgt);
    exp_q.push_back(nxt);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // redirect fetch to pc via a mispredicted not-taken branch at pc-4
  task automatic goto_pc(input logic [31:0] pc);
    step(1'b0, 1'b1, 1'b1, pc - 32'd4, 1'b0, 32'd0, 1'b1, 32'd0);
  endtask

  initial begin
    logic [31:0] epc, tgt, ptgt;
    bit          tk, ptk, cond;

    rst_n = 1'b0;
    stall = 1'b0; ex_valid = 1'b0; ex_is_cond = 1'b0; ex_pc = '0;
    ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("reset_pc", o_pc, RESET_PC);
    check_val("reset_pred", 32'(o_pred_taken), 32'd0);
    check_val("reset_flush", 32'(o_flush), 32'd0);
    rst_n = 1'b1;

    // sequential fetch
    for (int i = 0; i < 3; i++) begin
      check_val("seq_pc", o_pc, RESET_PC + 32'(4 * i));
      idle();
    end

    // BEQ @0x10010 taken to 0x10100, predicted not-taken
    step(1'b0, 1'b1, 1'b1, 32'h0001_0010, 1'b1, 32'h0001_0100, 1'b0, 32'd0);
    check_val("beq_redirect", o_pc, 32'h0001_0100);
    goto_pc(32'h0001_0010);
    check_val("beq_pred", 32'(o_pred_taken), 32'd1);
    check_val("beq_tgt", o_pred_target, 32'h0001_0100);

    // two not-taken resolutions: 10 -> 01 -> 00
    step(1'b0, 1'b1, 1'b1, 32'h0001_0010, 1'b0, 32'd0, 1'b1, 32'h0001_0100);
    step(1'b0, 1'b1, 1'b1, 32'h0001_0010, 1'b0, 32'd0, 1'b1, 32'h0001_0100);
    goto_pc(32'h0001_0010);
    check_val("beq_nt_pred", 32'(o_pred_taken), 32'd0);
    check_val("beq_nt_tgt", o_pred_target, 32'h0001_0100);

    // JAL @0x10020 -> 0x10200, then JALR retarget to 0x10300
    step(1'b0, 1'b1, 1'b0, 32'h0001_0020, 1'b1, 32'h0001_0200, 1'b0, 32'd0);
    goto_pc(32'h0001_0020);
    check_val("jal_pred", 32'(o_pred_taken), 32'd1);
    check_val("jal_tgt", o_pred_target, 32'h0001_0200);
    step(1'b0, 1'b1, 1'b0, 32'h0001_0020, 1'b1, 32'h0001_0300, 1'b1, 32'h0001_0200);
    check_val("jalr_redirect", o_pc, 32'h0001_0300);
    goto_pc(32'h0001_0020);
    check_val("jalr_pred", 32'(o_pred_taken), 32'd1);
    check_val("jalr_tgt", o_pred_target, 32'h0001_0300);

    // stall concurrent with flush: redirect wins
    step(1'b1, 1'b1, 1'b1, 32'h0001_0040, 1'b0, 32'd0, 1'b1, 32'd0);
    check_val("stall_flush_pc", o_pc, 32'h0001_0044);

    // stall alone holds PC while training continues
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 32'h0001_0060, 1'b1, 32'h0001_0500, 1'b1, 32'h0001_0500);
      check_val("stall_hold", o_pc, 32'h0001_0044);
    end
    goto_pc(32'h0001_0060);
    check_val("stall_train_pred", 32'(o_pred_taken), 32'd1);
    check_val("stall_train_tgt", o_pred_target, 32'h0001_0500);

    // aliasing: 0x10010 + 4*DEPTH replaces the 0x10010 entry
    step(1'b0, 1'b1, 1'b1, 32'h0001_0010 + 32'(4 * DEPTH), 1'b1, 32'h0001_0700, 1'b0, 32'd0);
    goto_pc(32'h0001_0010 + 32'(4 * DEPTH));
    check_val("alias_pred", 32'(o_pred_taken), 32'd1);
    check_val("alias_tgt", o_pred_target, 32'h0001_0700);
    goto_pc(32'h0001_0010);
    check_val("alias_old_pred", 32'(o_pred_taken), 32'd0);
    check_val("alias_old_tgt", o_pred_target, 32'h0001_0014);

    // address wrap
    goto_pc(32'hFFFF_FFFC);
    check_val("wrap_plus4", o_pcplus4, 32'd0);
    idle();
    check_val("wrap_pc", o_pc, 32'd0);

    // random traffic over a two-region address window (forces aliasing)
    goto_pc(RESET_PC);
    for (int n = 0; n < 500; n++) begin
      cond = ($urandom_range(0, 3) != 0);
      epc  = RESET_PC + 32'(4 * $urandom_range(0, 2 * DEPTH - 1));
      tk   = cond ? 1'($urandom_range(0, 1)) : 1'b1;
      tgt  = RESET_PC + 32'(4 * $urandom_range(0, 4 * DEPTH - 1));
      if ($urandom_range(0, 7) == 0) tgt = tgt | 32'd1;
      if ($urandom_range(0, 1) == 0) begin
        model_lookup(epc, ptk, ptgt);
      end else begin
        ptk  = 1'($urandom_range(0, 1));
        ptgt = RESET_PC + 32'(4 * $urandom_range(0, 4 * DEPTH - 1));
      end
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6), cond, epc, tk, tgt, ptk, ptgt);
    end

    // async reset mid-run
    stall = 1'b0; ex_valid = 1'b0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("midrst_pc", o_pc, RESET_PC);
    check_val("midrst_pred", 32'(o_pred_taken), 32'd0);
    check_val("midrst_flush", 32'(o_flush), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    idle();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      goto_pc(RESET_PC + 32'(4 * i));
      check_val("midrst_miss", 32'(o_pred_taken), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
